// File: rtl/cvxif_vec_issue_queue_if.sv
// ---------------------------------------------------------------------------
// cvxif_vec_issue_queue_if
//
// Bundles the CV-X-IF issue and commit channels and the dispatch channel
// toward the vector execution unit.
//
// Handshake semantics: a transfer on a valid/ready pair happens on a rising
// clock edge where both valid and ready are high. While valid is high and
// ready is low, the producer keeps valid and all payload signals unchanged.
// The commit channel is a strobe and has no ready signal.
//
// Modports:
//   master - core side: drives issue and commit, consumes dispatch
//   slave  - issue queue: answers issue, drives dispatch
//
// Signals:
//   issue_*  : issue request (valid/ready, instr, id, operands, decode result)
//   commit_* : commit/kill strobe with instruction id
//   op_*     : decoded and committed operation toward the execution unit
// ---------------------------------------------------------------------------
interface cvxif_vec_issue_queue_if #(
   parameter int unsigned IdWidth = 4
);
   logic               issue_valid_i;
   logic               issue_ready_o;
   logic [31:0]        issue_instr_i;
   logic [IdWidth-1:0] issue_id_i;
   logic [31:0]        issue_rs1_i;
   logic [31:0]        issue_rs2_i;
   logic [1:0]         issue_rs_valid_i;
   logic               issue_accept_o;
   logic               issue_writeback_o;

   logic               commit_valid_i;
   logic [IdWidth-1:0] commit_id_i;
   logic               commit_kill_i;

   logic               op_valid_o;
   logic               op_ready_i;
   logic [2:0]         op_o;
   logic [IdWidth-1:0] op_id_o;
   logic [31:0]        op_rs1_o;
   logic [31:0]        op_rs2_o;
   logic [4:0]         op_vd_o;
   logic [4:0]         op_vs1_o;
   logic [4:0]         op_vs2_o;
   logic [9:0]         op_vlen_in1_o;
   logic [9:0]         op_vlen_in2_o;
   logic [9:0]         op_vlen_out_o;

   modport master (
      output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
             issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, op_ready_i,
      input  issue_ready_o, issue_accept_o, issue_writeback_o, op_valid_o, op_o,
             op_id_o, op_rs1_o, op_rs2_o, op_vd_o, op_vs1_o, op_vs2_o,
             op_vlen_in1_o, op_vlen_in2_o, op_vlen_out_o
   );

   modport slave (
      input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
             issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, op_ready_i,
      output issue_ready_o, issue_accept_o, issue_writeback_o, op_valid_o, op_o,
             op_id_o, op_rs1_o, op_rs2_o, op_vd_o, op_vs1_o, op_vs2_o,
             op_vlen_in1_o, op_vlen_in2_o, op_vlen_out_o
   );
endinterface

// File: rtl/cvxif_vec_issue_queue.sv
// ---------------------------------------------------------------------------
// cvxif_vec_issue_queue
//
// Decode-and-hold stage for the custom vector coprocessor on CV-X-IF.
// Offered instructions are decoded combinationally and answered in the same
// cycle. Hits are buffered in an in-order queue until the core commits or
// kills them; committed entries are dispatched in order, killed entries are
// dropped silently at the head (one per cycle).
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous reset, active low
//   bus     - cvxif_vec_issue_queue_if.slave (issue, commit, dispatch)
//
// Parameters:
//   Depth   - queue entries, power of two, >= 2
//   IdWidth - CV-X-IF instruction id width
//
// Build option:
//   CVXIF_VEC_DISPATCH_REG_EN - when defined, a registered slot sits between
//   the queue head and the op_* outputs (one extra cycle of latency, still
//   one dispatch per cycle). When undefined, op_* come straight from the head.
// ---------------------------------------------------------------------------
module cvxif_vec_issue_queue #(
   parameter int unsigned Depth   = 4,
   parameter int unsigned IdWidth = 4
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   cvxif_vec_issue_queue_if.slave bus
);

   localparam int unsigned PtrW = $clog2(Depth);

   typedef enum logic [2:0] {
      OP_MV_V_X          = 3'd0,
      OP_MV_X_V          = 3'd1,
      OP_VADD2           = 3'd2,
      OP_NV12_TO_CAG444  = 3'd3,
      OP_CAG444_TO_RGB888 = 3'd4
   } custom_vec_op_e;

   typedef struct packed {
      custom_vec_op_e     op;
      logic [IdWidth-1:0] id;
      logic [31:0]        rs1;
      logic [31:0]        rs2;
      logic [4:0]         vd;
      logic [4:0]         vs1;
      logic [4:0]         vs2;
      logic [9:0]         vlen_in1;
      logic [9:0]         vlen_in2;
      logic [9:0]         vlen_out;
   } payload_t;

   // ---------------------------------------------------------------- decode
   logic           dec_hit;
   logic           dec_wb;
   custom_vec_op_e dec_op;
   logic [9:0]     dec_vlen_in1;
   logic [9:0]     dec_vlen_in2;
   logic [9:0]     dec_vlen_out;
   logic [31:0]    instr;

   assign instr = bus.issue_instr_i;

   always_comb begin
      dec_hit      = 1'b0;
      dec_wb       = 1'b0;
      dec_op       = OP_MV_V_X;
      dec_vlen_in1 = 10'd0;
      dec_vlen_in2 = 10'd0;
      dec_vlen_out = 10'd0;
      if (instr[6:0] == 7'b0001011 && instr[31:27] == 5'd0 && !instr[14]) begin
         case ({instr[26:25], instr[13:12]})
            4'b0000: begin
               dec_hit = 1'b1;
               dec_op  = OP_MV_V_X;
            end
            4'b0001: begin
               dec_hit = 1'b1;
               dec_op  = OP_MV_X_V;
               dec_wb  = 1'b1;
            end
            4'b0100: begin
               dec_hit      = 1'b1;
               dec_op       = OP_VADD2;
               dec_vlen_in1 = 10'd2;
               dec_vlen_in2 = 10'd2;
               dec_vlen_out = 10'd2;
            end
            4'b1000: begin
               dec_hit      = 1'b1;
               dec_op       = OP_NV12_TO_CAG444;
               dec_vlen_in1 = 10'd2;
               dec_vlen_in2 = 10'd2;
               dec_vlen_out = 10'd3;
            end
            4'b1100: begin
               dec_hit      = 1'b1;
               dec_op       = OP_CAG444_TO_RGB888;
               dec_vlen_in1 = 10'd3;
               dec_vlen_out = 10'd3;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- queue
   payload_t         q_pl [Depth];
   logic [Depth-1:0] committed_q;
   logic [Depth-1:0] killed_q;
   logic [PtrW:0]    wr_ptr_q;
   logic [PtrW:0]    rd_ptr_q;
   logic [PtrW:0]    count;
   logic [PtrW-1:0]  wr_idx;
   logic [PtrW-1:0]  rd_idx;
   logic             empty;
   logic             full;
   logic             enq;
   payload_t         enq_pl;

   assign wr_idx = wr_ptr_q[PtrW-1:0];
   assign rd_idx = rd_ptr_q[PtrW-1:0];
   assign count  = wr_ptr_q - rd_ptr_q;
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);

   // Ready does not depend on decode: misses complete the handshake too.
   assign bus.issue_ready_o     = !full && (&bus.issue_rs_valid_i);
   assign bus.issue_accept_o    = bus.issue_valid_i && dec_hit;
   assign bus.issue_writeback_o = bus.issue_valid_i && dec_hit && dec_wb;
   assign enq = bus.issue_valid_i && bus.issue_ready_o && dec_hit;

   always_comb begin
      enq_pl          = '0;
      enq_pl.op       = dec_op;
      enq_pl.id       = bus.issue_id_i;
      enq_pl.rs1      = bus.issue_rs1_i;
      enq_pl.rs2      = bus.issue_rs2_i;
      enq_pl.vd       = instr[11:7];
      enq_pl.vs1      = instr[19:15];
      enq_pl.vs2      = instr[24:20];
      enq_pl.vlen_in1 = dec_vlen_in1;
      enq_pl.vlen_in2 = dec_vlen_in2;
      enq_pl.vlen_out = dec_vlen_out;
   end

   // Commit lookup: scan from the head so the oldest open match wins. Only
   // if no queued entry matches does the commit fall through to the entry
   // being enqueued this cycle.
   logic            cm_found;
   logic [PtrW-1:0] cm_idx;
   logic [PtrW-1:0] scan_idx;
   logic            cm_old;
   logic            cm_new;

   always_comb begin
      cm_found = 1'b0;
      cm_idx   = '0;
      scan_idx = '0;
      for (int i = 0; i < Depth; i++) begin
         scan_idx = rd_idx + PtrW'(i);
         if (!cm_found && ((PtrW+1)'(i) < count) &&
             q_pl[scan_idx].id == bus.commit_id_i &&
             !committed_q[scan_idx] && !killed_q[scan_idx]) begin
            cm_found = 1'b1;
            cm_idx   = scan_idx;
         end
      end
   end

   assign cm_old = bus.commit_valid_i && cm_found;
   assign cm_new = bus.commit_valid_i && !cm_found && enq &&
                   (bus.commit_id_i == bus.issue_id_i);

   // ---------------------------------------------------------------- head
   payload_t head_pl;
   logic     head_live;
   logic     head_drop;
   logic     head_pop;

   assign head_pl   = q_pl[rd_idx];
   assign head_live = !empty && committed_q[rd_idx] && !killed_q[rd_idx];
   assign head_drop = !empty && killed_q[rd_idx];

   payload_t out_pl;
   logic     out_valid;

`ifdef CVXIF_VEC_DISPATCH_REG_EN
   payload_t slot_q;
   logic     slot_valid_q;
   logic     slot_load;

   // The slot refills in the same cycle it drains, keeping one per cycle.
   assign slot_load = head_live && (!slot_valid_q || bus.op_ready_i);
   assign head_pop  = head_drop || slot_load;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q       <= '0;
         slot_valid_q <= 1'b0;
      end else if (slot_load) begin
         slot_q       <= head_pl;
         slot_valid_q <= 1'b1;
      end else if (slot_valid_q && bus.op_ready_i) begin
         slot_q       <= '0;
         slot_valid_q <= 1'b0;
      end
   end

   assign out_pl    = slot_q;
   assign out_valid = slot_valid_q;
`else
   assign head_pop  = head_drop || (head_live && bus.op_ready_i);
   assign out_pl    = head_live ? head_pl : '0;
   assign out_valid = head_live;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            q_pl[i] <= '0;
         end
         committed_q <= '0;
         killed_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         // The enqueue slot is never an occupied entry, so it cannot collide
         // with cm_idx.
         if (enq) begin
            q_pl[wr_idx]        <= enq_pl;
            committed_q[wr_idx] <= cm_new && !bus.commit_kill_i;
            killed_q[wr_idx]    <= cm_new && bus.commit_kill_i;
            wr_ptr_q            <= wr_ptr_q + 1'b1;
         end
         if (cm_old) begin
            if (bus.commit_kill_i) begin
               killed_q[cm_idx] <= 1'b1;
            end else begin
               committed_q[cm_idx] <= 1'b1;
            end
         end
         if (head_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign bus.op_valid_o    = out_valid;
   assign bus.op_o          = out_pl.op;
   assign bus.op_id_o       = out_pl.id;
   assign bus.op_rs1_o      = out_pl.rs1;
   assign bus.op_rs2_o      = out_pl.rs2;
   assign bus.op_vd_o       = out_pl.vd;
   assign bus.op_vs1_o      = out_pl.vs1;
   assign bus.op_vs2_o      = out_pl.vs2;
   assign bus.op_vlen_in1_o = out_pl.vlen_in1;
   assign bus.op_vlen_in2_o = out_pl.vlen_in2;
   assign bus.op_vlen_out_o = out_pl.vlen_out;

endmodule
